// File: rtl/ram_stream_reader_pkg.sv
// ============================================================================
// ram_stream_reader_pkg
//   Shared state encoding, defaults and address-width helper for the reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_stream_reader_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 512;
    localparam int BUF_ENTRIES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Number of bits needed to hold the value (at least 1); the RAM sizes its
    // address port as addr_bits(DEPTH-1).
    function automatic int addr_bits(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_stream_reader_if.sv
// ============================================================================
// ram_stream_reader_if
//   RAM read port plus valid/ready output stream of the reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_stream_reader_if
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = addr_bits(DEFAULT_DEPTH - 1)
) ();

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]      ram_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;

    modport master (
        output ram_addr,
        input  ram_q,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  ram_addr,
        output ram_q,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface

`default_nettype wire

// File: rtl/ram_stream_reader_stream_skid_buf.sv
// ============================================================================
// stream_skid_buf
//   Two-entry registered FIFO with valid/ready output; push and pop may coincide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_valid,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  wire logic             pop_ready,
    output logic [WIDTH-1:0]      pop_data,
    output logic [1:0]            count
);

    localparam logic [1:0] c_full = 2'(BUF_ENTRIES);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;
    logic             push;

    assign pop_valid = (count_q != 2'd0);
    assign pop_data  = head_q;
    assign count     = count_q;

    assign pop  = pop_valid & pop_ready;
    // A full buffer only takes a new word when the head leaves in the same cycle.
    assign push = push_valid & ((count_q != c_full) | pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == c_full) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// ============================================================================
// ram_stream_reader
//   Reads (base, length) words from a registered-read RAM onto a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = addr_bits(DEPTH - 1),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    input  wire logic [LEN_WIDTH-1:0]  length,
    output logic                       busy,
    output logic                       done,
    ram_stream_reader_if.master        bus
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;

    logic [1:0]            buf_count;
    logic                  buf_valid;
    logic [WIDTH-1:0]      buf_data;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign pop = buf_valid & bus.out_ready;

    // Words that will be held after this edge if nothing new is issued.
    assign occupancy = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == ST_RUN) && (remaining_q != '0) && (occupancy < 3'd2);
    assign next_addr = (addr_q == c_last_addr) ? '0 : addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    state_d     = (length == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d      = next_addr;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                end
                if ((remaining_q == '0) && !inflight_q && (buf_count == 2'd1) && pop) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    // The read issued last cycle is on ram_q now; capture it into the buffer.
    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (inflight_q),
        .push_data  (bus.ram_q),
        .pop_valid  (buf_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (buf_data),
        .count      (buf_count)
    );

    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_FIN);
    assign bus.ram_addr  = addr_q;
    assign bus.out_valid = buf_valid;
    assign bus.out_data  = buf_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// ============================================================================
// tb_ram_stream_reader
//   Self-checking bench: RAM model, queue-based expected stream, per-cycle compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_stream_reader;
    import ram_stream_reader_pkg::*;

    localparam int WIDTH = 64;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;

    ram_stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

    ram_stream_reader #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit pending = 0, first_busy = 0, prev_v = 0, prev_r = 0;
    logic [63:0] prev_d = '0;
    logic [AW-1:0] prev_addr = '0;
    int issued = 0, popped = 0, cur_len = 0, accept_cyc = 0, last_hs = 0;
    int done_cnt = 0, last_done_cyc = 0, first_valid_cyc = -1;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle out of reset, checked against the queue model.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            cyc++;
            if (prev_v && !prev_r) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_d);
            end
            if (busy) begin
                if (first_busy) begin
                    prev_addr  = bus.ram_addr;
                    first_busy = 1'b0;
                end else if (bus.ram_addr != prev_addr) begin
                    chk("addr_step", bus.ram_addr,
                        (prev_addr == AW'(DEPTH - 1)) ? 64'd0 : 64'(prev_addr) + 64'd1);
                    issued++;
                    prev_addr = bus.ram_addr;
                end
                chk("outstanding_le2", ((issued - popped) <= 2), 1);
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat_data", bus.out_data, exp_q.pop_front());
                got_q.push_back(bus.out_data);
                popped++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_expected", pending, 1);
                chk("busy_low_at_done", busy, 0);
                chk("beats_left_at_done", exp_q.size(), 0);
                chk("issued_eq_len", issued, cur_len);
                chk("done_timing", cyc, (cur_len == 0) ? accept_cyc : last_hs + 1);
                pending = 1'b0;
            end
            if (!busy && !done) chk("idle_no_valid", bus.out_valid, 0);
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
            prev_d = bus.out_data;
        end
    end

    task automatic issue_cmd(input int b, input int len);
        @(posedge clk); #1;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
        cur_len = len; pending = 1'b1; issued = 0; popped = 0;
        first_busy = 1'b1; first_valid_cyc = -1; accept_cyc = cyc + 2;
        start = 1'b1; base_addr = AW'(b); length = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        #1 rst_n = 1'b0;
        exp_q.delete();
        pending = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // mode 0: ready held; 1: 1,0,0,1,0,1 pattern with a 10-cycle stall; 2: random
    task automatic run_until_done(input int mode, input int inject_at, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = (k >= 12 && k < 22) ? 1'b0 : pat[k % 6];
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (k == inject_at) begin
                start = 1'b1;
                base_addr = base_addr + AW'(37);
                length = LW'(3);
            end else begin
                start = 1'b0;
            end
            k++;
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            chk("timeout", 0, 1);
            do_reset(2);
        end
    endtask

    task automatic chk_got(input string nm, input int first_val, input logic [AW-1:0] wrap_at);
        chk({nm, "_count"}, got_q.size(), cur_len);
        for (int i = 0; i < got_q.size(); i++) begin
            int a;
            a = first_val + i;
            if (wrap_at != '0 && i >= int'(wrap_at)) a = 100 + (i - int'(wrap_at));
            chk({nm, "_word"}, got_q[i], 64'(a));
        end
    endtask

    initial begin
        int d_before;
        int b;
        int l;
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i + 100);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_data", bus.out_data, 0);
        rst_n = 1'b1;

        // base 5, length 4, ready held: 105..108 back-to-back
        bus.out_ready = 1'b1;
        issue_cmd(5, 4);
        run_until_done(0, -1, 100);
        chk_got("t1", 105, '0);
        chk("t1_first_valid", first_valid_cyc, accept_cyc + 2);
        chk("t1_done_cycle", last_done_cyc, accept_cyc + 6);

        // wrap: 510, 511, 0, 1
        issue_cmd(DEPTH - 2, 4);
        run_until_done(0, -1, 100);
        chk_got("t2", 610, AW'(2));

        // zero length
        issue_cmd(7, 0);
        run_until_done(0, -1, 20);
        chk("t3_no_beats", got_q.size(), 0);
        chk("t3_done_cycle", last_done_cyc, accept_cyc);

        // toggling ready with a long stall
        issue_cmd(0, 8);
        run_until_done(1, -1, 200);
        chk_got("t4", 100, '0);

        // start while busy is ignored
        d_before = done_cnt;
        issue_cmd(40, 6);
        run_until_done(0, 2, 100);
        chk_got("t5", 140, '0);
        chk("t5_one_done", done_cnt, d_before + 1);

        // reset after 3 of 6 beats
        d_before = done_cnt;
        bus.out_ready = 1'b1;
        issue_cmd(60, 6);
        for (int k = 0; k < 50 && popped < 3; k++) begin
            @(posedge clk); #2;
        end
        chk("t6_three_beats", popped, 3);
        rst_n = 1'b0;
        exp_q.delete();
        pending = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_addr", bus.ram_addr, 0);
        chk("t6_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_no_done", done_cnt, d_before);
        issue_cmd(20, 2);
        run_until_done(0, -1, 50);
        chk_got("t6b", 120, '0);

        // randomized commands against fresh random RAM contents
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        for (int n = 0; n < 16; n++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 24);
            d_before = done_cnt;
            issue_cmd(b, l);
            run_until_done($urandom_range(0, 2), (n % 4 == 0) ? 3 : -1, 400);
            chk("rnd_count", got_q.size(), l);
            chk("rnd_one_done", done_cnt, d_before + 1);
        end
        issue_cmd($urandom_range(0, DEPTH - 1), DEPTH);
        run_until_done(2, -1, 4000);
        chk("full_count", got_q.size(), DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
